// File: rtl/base_mem_arb.sv
// Purpose : round-robin arbiter sharing one synchronous single-port memory between two requesters.
// Latency : valid sampled in IDLE at cycle N -> mem_addr/mem_wen during N+1 -> req_ready/req_rdata during N+2.
// Backpr. : one access in flight; the losing or late port holds valid until its req_ready pulse (1 access / 3 cycles).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid[1:0]             per-port request
//   req_addr0/1  [23:0]        byte address (bits [1:0] ignored)
//   req_wdata0/1 [31:0]        write data
//   req_wstrb0/1 [3:0]         byte strobes, 0 = read
//   req_ready[1:0]             one-cycle completion pulse to the granted port
//   req_rdata[31:0]            read data, zero unless a req_ready bit is high
//   mem_addr[21:0]             word address to memory
//   mem_wen[3:0]               byte write enables to memory
//   mem_wdata[31:0]            write data to memory
//   mem_rdata[31:0]            memory read data, one cycle after mem_addr
module base_mem_arb #(
  parameter int unsigned WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [23:0] req_addr0,
  input  logic [23:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  input  logic [3:0]  req_wstrb0,
  input  logic [3:0]  req_wstrb1,
  output logic [1:0]  req_ready,
  output logic [31:0] req_rdata,
  output logic [21:0] mem_addr,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] WORDS_W = 32'(WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        in_range_q, in_range_d;
  logic [21:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wen_q, mem_wen_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  req_ready_q, req_ready_d;

  // Winner selection: under contention the port that did not win last time
  // gets the slot; otherwise whichever port is asking.
  logic        win;
  logic [23:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        sel_in_range;

  always_comb begin
    if (&req_valid) begin
      win = ~last_grant_q;
    end else begin
      win = req_valid[1];
    end
    sel_addr     = win ? req_addr1  : req_addr0;
    sel_wdata    = win ? req_wdata1 : req_wdata0;
    sel_wstrb    = win ? req_wstrb1 : req_wstrb0;
    sel_in_range = ({10'd0, sel_addr[23:2]} < WORDS_W);
  end

  // Byte-offset bits never reach the word-addressed memory.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^sel_addr[1:0];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    in_range_d   = in_range_q;
    mem_addr_d   = mem_addr_q;
    mem_wen_d    = mem_wen_q;
    mem_wdata_d  = mem_wdata_q;
    req_ready_d  = 2'b00;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_d      = win;
          last_grant_d = win;
          mem_addr_d   = sel_addr[23:2];
          mem_wdata_d  = sel_wdata;
          in_range_d   = sel_in_range;
          // Out-of-range writes are suppressed here so memory never sees them.
          mem_wen_d    = sel_in_range ? sel_wstrb : 4'h0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Memory captures address/write this cycle; ready is staged so that
        // it lines up with mem_rdata in the following cycle.
        mem_wen_d   = 4'h0;
        req_ready_d = grant_q ? 2'b10 : 2'b01;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      in_range_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wen_q    <= '0;
      mem_wdata_q  <= '0;
      req_ready_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      in_range_q   <= in_range_d;
      mem_addr_q   <= mem_addr_d;
      mem_wen_q    <= mem_wen_d;
      mem_wdata_q  <= mem_wdata_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wen   = mem_wen_q;
  assign mem_wdata = mem_wdata_q;

  // Only combinational output: memory data passed through during RESP,
  // forced to zero for out-of-range accesses and at all other times.
  assign req_rdata = ((state_q == ST_RESP) && in_range_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_base_mem_arb.sv
// Purpose : randomized + directed bench for base_mem_arb against a transaction-level model.
// Latency : model predicts mem access one cycle and completion two cycles after acceptance.
// Backpr. : requesters hold requests until their completion pulse, then may issue again.
module tb_base_mem_arb;

  localparam int WORDS = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [23:0] req_addr0, req_addr1;
  logic [31:0] req_wdata0, req_wdata1;
  logic [3:0]  req_wstrb0, req_wstrb1;
  logic [1:0]  req_ready;
  logic [31:0] req_rdata;
  logic [21:0] mem_addr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  base_mem_arb #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .req_wstrb0 (req_wstrb0),
    .req_wstrb1 (req_wstrb1),
    .req_ready  (req_ready),
    .req_rdata  (req_rdata),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [31:0] seed_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // Attached memory: synchronous, byte writes, read-during-write returns old data.
  logic [31:0] tmem [512];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) tmem[i] <= seed_word(i);
      mem_init <= 1'b1;
    end else begin
      mem_rdata <= tmem[mem_addr[8:0]];
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) tmem[mem_addr[8:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  // Model state
  logic [31:0] ref_mem [WORDS];
  int          cyc = 0;
  int          done_cyc = -100;
  int          acc_cyc = -100;
  bit          done_port;
  bit          last_grant;
  logic [31:0] done_rdata;
  logic [21:0] exp_addr;
  logic [3:0]  exp_wen;
  logic [31:0] exp_wdata;

  bit          pend [2];
  logic [23:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [3:0]  pwstrb [2];
  int          refill [2];
  int          vld_cyc [2];
  int          rdy_obs_cyc [2];
  logic [31:0] rdata_obs [2];
  bit          rand_mode;
  int          grant_log [$];
  int          done_log [$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic set_req(int p, logic [23:0] a, logic [31:0] d, logic [3:0] s);
    pend[p] = 1'b1; paddr[p] = a; pwdata[p] = d; pwstrb[p] = s; vld_cyc[p] = -1;
  endtask

  task automatic rand_req(int p);
    int unsigned w;
    w = ($urandom_range(7) == 0) ? 256 + $urandom_range(255) : $urandom_range(255);
    set_req(p, 24'(w * 4 + $urandom_range(3)), $urandom,
            ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'h0);
  endtask

  task automatic reset_dut(int n);
    rst_n = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0; refill[0] = 0; refill[1] = 0;
    rand_mode = 1'b0; req_valid = 2'b00;
    done_cyc = -100; acc_cyc = -100; last_grant = 1'b1;
    repeat (n) begin
      @(negedge clk); cyc++;
      chk_eq("rst_ready", 32'(req_ready), 32'h0);
      chk_eq("rst_rdata", req_rdata, 32'h0);
      chk_eq("rst_wen",   32'(mem_wen), 32'h0);
      chk_eq("rst_addr",  32'(mem_addr), 32'h0);
      chk_eq("rst_wdata", mem_wdata, 32'h0);
    end
    rst_n = 1'b1;
  endtask

  // One clock: check this cycle's outputs, retire/refill requesters, drive, and
  // let the model accept a new transaction if the arbiter is free.
  task automatic cycle();
    @(negedge clk); cyc++;
    chk_eq("req_ready", 32'(req_ready),
           (cyc == done_cyc) ? (done_port ? 32'h2 : 32'h1) : 32'h0);
    chk_eq("req_rdata", req_rdata, (cyc == done_cyc) ? done_rdata : 32'h0);
    chk_eq("mem_wen", 32'(mem_wen), (cyc == done_cyc - 1) ? 32'(exp_wen) : 32'h0);
    if (cyc == done_cyc - 1) begin
      chk_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
      if (exp_wen != 4'h0) chk_eq("mem_wdata", mem_wdata, exp_wdata);
    end
    for (int p = 0; p < 2; p++)
      if (req_ready[p]) begin rdy_obs_cyc[p] = cyc; rdata_obs[p] = req_rdata; end
    if (cyc == done_cyc) begin
      pend[done_port] = 1'b0;
      grant_log.push_back(int'(done_port));
      done_log.push_back(cyc);
    end
    for (int p = 0; p < 2; p++)
      if (!pend[p] && (refill[p] > 0 || (rand_mode && $urandom_range(1) == 0))) begin
        if (refill[p] > 0) refill[p]--;
        rand_req(p);
      end
    req_valid  = {pend[1], pend[0]};
    req_addr0  = paddr[0];  req_addr1  = paddr[1];
    req_wdata0 = pwdata[0]; req_wdata1 = pwdata[1];
    req_wstrb0 = pwstrb[0]; req_wstrb1 = pwstrb[1];
    for (int p = 0; p < 2; p++) if (pend[p] && vld_cyc[p] < 0) vld_cyc[p] = cyc;
    if (cyc > done_cyc && (pend[0] || pend[1])) begin
      int          w;
      logic [21:0] word;
      bit          inr;
      if (pend[0] && pend[1]) w = last_grant ? 0 : 1;
      else                    w = pend[1] ? 1 : 0;
      last_grant = (w == 1);
      done_port  = (w == 1);
      acc_cyc    = cyc;
      done_cyc   = cyc + 2;
      word       = paddr[w][23:2];
      inr        = (int'(word) < WORDS);
      exp_addr   = word;
      exp_wen    = inr ? pwstrb[w] : 4'h0;
      exp_wdata  = pwdata[w];
      done_rdata = inr ? ref_mem[word[7:0]] : 32'h0;
      if (inr)
        for (int b = 0; b < 4; b++)
          if (pwstrb[w][b]) ref_mem[word[7:0]][b*8 +: 8] = pwdata[w][b*8 +: 8];
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((pend[0] || pend[1] || cyc <= done_cyc) && n < 2000) begin
      cycle(); n++;
    end
    if (n >= 2000) chk_eq("drain_timeout", 32'h1, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = seed_word(i);
    for (int p = 0; p < 2; p++) begin
      paddr[p] = '0; pwdata[p] = '0; pwstrb[p] = '0; vld_cyc[p] = -1; rdy_obs_cyc[p] = -1;
    end
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    req_wstrb0 = '0; req_wstrb1 = '0;
    reset_dut(3);

    // Idle: nothing requested for 20 cycles
    repeat (20) cycle();

    // Single write then read on port 0
    set_req(0, 24'h10, 32'hDEAD_BEEF, 4'hF); wait_idle();
    set_req(0, 24'h10, 32'h0, 4'h0);         wait_idle();
    chk_eq("rd_latency", 32'(rdy_obs_cyc[0] - vld_cyc[0]), 32'd2);
    chk_eq("rd_deadbeef", rdata_obs[0], 32'hDEAD_BEEF);

    // Byte strobe merge
    set_req(0, 24'h20, 32'h1122_3344, 4'hF); wait_idle();
    set_req(0, 24'h20, 32'h0000_00AA, 4'h1); wait_idle();
    set_req(0, 24'h22, 32'h0, 4'h0);         wait_idle();
    chk_eq("rd_bytestrb", rdata_obs[0], 32'h1122_33AA);

    // Out of range on port 1: write suppressed, read returns zero
    set_req(1, 24'h400, 32'hFFFF_FFFF, 4'hF); wait_idle();
    set_req(1, 24'h400, 32'h0, 4'h0);         wait_idle();
    chk_eq("rd_oor_zero", rdata_obs[1], 32'h0);
    set_req(1, 24'h0, 32'h0, 4'h0);           wait_idle();
    chk_eq("rd_word0_kept", rdata_obs[1], seed_word(0));

    // Contention: four accesses per port, alternating from port 0
    reset_dut(2);
    grant_log.delete(); done_log.delete();
    rand_req(0); rand_req(1); refill[0] = 3; refill[1] = 3;
    wait_idle();
    chk_eq("cont_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < grant_log.size() && i < 8; i++)
      chk_eq("cont_order", 32'(grant_log[i]), 32'(i % 2));
    for (int i = 1; i < done_log.size(); i++)
      chk_eq("cont_spacing", 32'(done_log[i] - done_log[i-1]), 32'd3);

    // Reset during ISSUE of a port-1 read
    begin
      int n;
      int p1_rdy_before;
      p1_rdy_before = rdy_obs_cyc[1];
      set_req(1, 24'h44, 32'h0, 4'h0);
      n = 0;
      do begin cycle(); n++; end while (acc_cyc != cyc && n < 20);
      chk_eq("midop_accept", 32'(acc_cyc == cyc), 32'h1);
      @(posedge clk); #2;
      reset_dut(2);
      chk_eq("midop_no_ready", 32'(rdy_obs_cyc[1]), 32'(p1_rdy_before));
      set_req(0, 24'h10, 32'h0, 4'h0); wait_idle();
      chk_eq("midop_p0_lat", 32'(rdy_obs_cyc[0] - vld_cyc[0]), 32'd2);
      chk_eq("midop_p1_quiet", 32'(rdy_obs_cyc[1]), 32'(p1_rdy_before));
    end

    // Randomized traffic from both ports
    rand_mode = 1'b1;
    repeat (900) cycle();
    rand_mode = 1'b0;
    wait_idle();
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
